// File: rtl/dmem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmem_ctrl_pkg
// Shared definitions for the data-memory access controller:
//   - dmem_state_t : controller FSM encoding (IDLE / BUSY / DONE)
//   - DMEM_TIMEOUT : default number of BUSY cycles allowed without bus_ack
//   - is_word_aligned() : word-alignment test on the two low address bits
// -----------------------------------------------------------------------------
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_t;

    localparam int DMEM_TIMEOUT = 64;

    // Only whole-word accesses are supported; the two low bits must be zero.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_ctrl_timer.sv
// -----------------------------------------------------------------------------
// dmem_timer
// Clear/enable up-counter with a terminal-count flag, used to bound how long
// the controller waits for bus_ack.
// Ports:
//   i_clk     : clock, rising edge
//   i_rst_n   : asynchronous active-low reset (count -> 0)
//   i_clear   : synchronous clear, has priority over i_enable
//   i_enable  : increment by one
//   o_tc      : count has reached TIMEOUT_CYC-1
// -----------------------------------------------------------------------------
module dmem_timer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
// Data-memory access controller sitting behind mem_stage. Turns one load or
// store request into a single word transaction on a req/ack bus of variable
// latency, stalls the pipeline until it completes, and pulses mem_err on
// misaligned, illegal (load+store) or timed-out accesses.
// Ports:
//   clk, reset                 : clock and asynchronous active-low reset
//   ram_addr_mem, ram_data_mem : access address / store data from mem_stage
//   ram_read_enable            : load request
//   ram_write_enable           : store request
//   ram_data                   : last completed load value
//   mem_stall                  : freeze IF..MEM while an access is pending
//   mem_err                    : one-cycle error pulse (in the DONE cycle)
//   bus_req/bus_we/bus_addr/bus_wdata : bus request side, held until ack
//   bus_rdata/bus_ack          : bus response side
// -----------------------------------------------------------------------------
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = DMEM_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ram_addr_mem,
    input  logic [DATA_W-1:0] ram_data_mem,
    input  logic              ram_read_enable,
    input  logic              ram_write_enable,
    output logic [DATA_W-1:0] ram_data,
    output logic              mem_stall,
    output logic              mem_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    dmem_state_t       r_state;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [DATA_W-1:0] r_ram_data;
    logic              r_mem_err;

    logic w_req;
    logic w_illegal;
    logic w_misaligned;
    logic w_timer_clear;
    logic w_timer_en;
    logic w_timer_tc;

    assign w_req        = ram_read_enable | ram_write_enable;
    assign w_illegal    = ram_read_enable & ram_write_enable;
    assign w_misaligned = !is_word_aligned(ram_addr_mem[1:0]);

    // The timer only runs in BUSY, so it always starts from zero on the first
    // BUSY cycle. An ack cycle does not count toward the timeout.
    assign w_timer_clear = (r_state != DMEM_BUSY);
    assign w_timer_en    = (r_state == DMEM_BUSY) && !bus_ack;

    dmem_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_en),
        .o_tc     (w_timer_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= DMEM_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_ram_data  <= '0;
            r_mem_err   <= 1'b0;
        end else begin
            // mem_err is a single-cycle pulse; it is only set on entry to DONE.
            r_mem_err <= 1'b0;
            case (r_state)
                DMEM_IDLE: begin
                    if (w_req) begin
                        if (w_misaligned || w_illegal) begin
                            r_mem_err <= 1'b1;
                            r_state   <= DMEM_DONE;
                        end else begin
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= ram_write_enable;
                            r_bus_addr  <= ram_addr_mem;
                            r_bus_wdata <= ram_data_mem;
                            r_state     <= DMEM_BUSY;
                        end
                    end
                end
                DMEM_BUSY: begin
                    // Ack is checked first so an ack on the last allowed
                    // cycle still completes normally.
                    if (bus_ack) begin
                        r_bus_req <= 1'b0;
                        if (!r_bus_we) begin
                            r_ram_data <= bus_rdata;
                        end
                        r_state <= DMEM_DONE;
                    end else if (w_timer_tc) begin
                        r_bus_req <= 1'b0;
                        r_mem_err <= 1'b1;
                        r_state   <= DMEM_DONE;
                    end
                end
                DMEM_DONE: begin
                    r_state <= DMEM_IDLE;
                end
                default: begin
                    r_state   <= DMEM_IDLE;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    // Combinational so the pipeline freezes in the same cycle the request
    // appears; drops in DONE so mem_stage advances at the end of DONE.
    assign mem_stall = ((r_state == DMEM_IDLE) && w_req) || (r_state == DMEM_BUSY);

    assign ram_data  = r_ram_data;
    assign mem_err   = r_mem_err;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;

endmodule
